// File: rtl/mcdf_formatter.sv
// MCDF packet formatter: buffers a fixed-length burst from the arbiter and replays it as a framed packet.
// Build option MCDF_FMT_PARITY_EN adds fmt_parity, the registered XOR reduction of fmt_data during SEND.
module mcdf_formatter #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 32,
  parameter int CHID_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arb_valid,
  input  logic [CHID_WIDTH-1:0] arb_id,
  input  logic [DATA_WIDTH-1:0] arb_data,
  output logic                  arb_ready,
  input  logic [2:0]            len_sel,
  input  logic                  fmt_grant,
  output logic                  fmt_req,
  output logic [CHID_WIDTH-1:0] fmt_chid,
  output logic [5:0]            fmt_length,
  output logic [DATA_WIDTH-1:0] fmt_data,
  output logic                  fmt_start,
  output logic                  fmt_end
`ifdef MCDF_FMT_PARITY_EN
  ,
  output logic                  fmt_parity
`endif
);

  // state   | meaning
  // IDLE    | waiting for the first word of a packet
  // COLLECT | filling the buffer until pkt_len words are held
  // REQ     | packet buffered, fmt_req high, waiting for fmt_grant
  // SEND    | one buffered word per cycle on fmt_data
  // GAP     | single dead cycle after fmt_end
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_REQ, S_SEND, S_GAP} state_t;

  localparam int PTR_W = 5;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  state_t                state;
  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      last_idx;
  logic [5:0]            cnt;
  logic [5:0]            pkt_len;
  logic [CHID_WIDTH-1:0] pkt_id;
  logic                  xfer;

  function automatic logic [5:0] decode_len(input logic [2:0] sel);
    case (sel)
      3'd0:    decode_len = 6'd4;
      3'd1:    decode_len = 6'd8;
      3'd2:    decode_len = 6'd16;
      default: decode_len = 6'd32;
    endcase
  endfunction

  assign arb_ready = (state == S_IDLE) || (state == S_COLLECT);
  assign xfer      = arb_valid && arb_ready;
  assign last_idx  = PTR_W'(pkt_len - 6'd1);

  // Buffer needs no reset: stale entries are never read because pointers restart per packet.
  always_ff @(posedge clk) begin
    if (xfer) buf_mem[(state == S_IDLE) ? '0 : wr_ptr] <= arb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      pkt_len    <= '0;
      pkt_id     <= '0;
      fmt_req    <= 1'b0;
      fmt_chid   <= '0;
      fmt_length <= '0;
      fmt_data   <= '0;
      fmt_start  <= 1'b0;
      fmt_end    <= 1'b0;
`ifdef MCDF_FMT_PARITY_EN
      fmt_parity <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            pkt_id  <= arb_id;
            pkt_len <= decode_len(len_sel);
            wr_ptr  <= PTR_ONE;
            cnt     <= 6'd1;
            state   <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          // Later words are attributed to pkt_id whatever arb_id shows.
          if (xfer) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            cnt    <= cnt + 6'd1;
            if (cnt + 6'd1 == pkt_len) begin
              state      <= S_REQ;
              fmt_req    <= 1'b1;
              fmt_chid   <= pkt_id;
              fmt_length <= pkt_len;
            end
          end
        end
        S_REQ: begin
          if (fmt_grant) begin
            state     <= S_SEND;
            fmt_req   <= 1'b0;
            fmt_start <= 1'b1;
            fmt_end   <= (last_idx == '0);
            fmt_data  <= buf_mem[0];
            rd_ptr    <= PTR_ONE;
`ifdef MCDF_FMT_PARITY_EN
            fmt_parity <= ^buf_mem[0];
`endif
          end
        end
        S_SEND: begin
          fmt_start <= 1'b0;
          if (fmt_end) begin
            state   <= S_GAP;
            fmt_end <= 1'b0;
`ifdef MCDF_FMT_PARITY_EN
            fmt_parity <= 1'b0;
`endif
          end else begin
            fmt_data <= buf_mem[rd_ptr];
            fmt_end  <= (rd_ptr == last_idx);
            rd_ptr   <= rd_ptr + PTR_ONE;
`ifdef MCDF_FMT_PARITY_EN
            fmt_parity <= ^buf_mem[rd_ptr];
`endif
          end
        end
        S_GAP: begin
          state  <= S_IDLE;
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_formatter.sv
// Scoreboard bench for mcdf_formatter: stimulus queues expected packet words and point checks,
// a negedge monitor pops and compares them. Define MCDF_FMT_PARITY_EN to also cover fmt_parity.
module tb_mcdf_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_valid;
  logic [1:0]  arb_id;
  logic [31:0] arb_data;
  logic        arb_ready;
  logic [2:0]  len_sel;
  logic        fmt_grant;
  logic        fmt_req;
  logic [1:0]  fmt_chid;
  logic [5:0]  fmt_length;
  logic [31:0] fmt_data;
  logic        fmt_start;
  logic        fmt_end;
`ifdef MCDF_FMT_PARITY_EN
  logic        fmt_parity;
`endif

  always #5 clk = ~clk;

  mcdf_formatter dut (
    .clk        (clk),
    .rst        (rst),
    .arb_valid  (arb_valid),
    .arb_id     (arb_id),
    .arb_data   (arb_data),
    .arb_ready  (arb_ready),
    .len_sel    (len_sel),
    .fmt_grant  (fmt_grant),
    .fmt_req    (fmt_req),
    .fmt_chid   (fmt_chid),
    .fmt_length (fmt_length),
    .fmt_data   (fmt_data),
    .fmt_start  (fmt_start),
    .fmt_end    (fmt_end)
`ifdef MCDF_FMT_PARITY_EN
    ,
    .fmt_parity (fmt_parity)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        start;
    logic        last;
    logic [1:0]  chid;
    logic [5:0]  len;
    logic        par;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] exp;
  } pchk_t;

  exp_t  exp_q[$];
  pchk_t pchk_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  in_pkt = 1'b0;

  // Monitor: the only process that counts and reports comparisons.
  always @(negedge clk) begin
    exp_t  e;
    pchk_t p;
    while (pchk_q.size() > 0) begin
      p = pchk_q.pop_front();
      checks++;
      if (p.got !== p.exp) begin
        errors++;
        $display("FAIL %s got %0h exp %0h", p.name, p.got, p.exp);
      end
    end
    if (rst) in_pkt = 1'b0;
    else begin
      if (fmt_start) in_pkt = 1'b1;
      if (in_pkt) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected got data=%h start=%b end=%b", fmt_data, fmt_start, fmt_end);
        end else begin
          e = exp_q.pop_front();
          if ({fmt_data, fmt_start, fmt_end, fmt_chid, fmt_length} !==
              {e.data, e.start, e.last, e.chid, e.len}) begin
            errors++;
            $display("FAIL word got data=%h start=%b end=%b chid=%0d len=%0d exp data=%h start=%b end=%b chid=%0d len=%0d",
                     fmt_data, fmt_start, fmt_end, fmt_chid, fmt_length,
                     e.data, e.start, e.last, e.chid, e.len);
          end
`ifdef MCDF_FMT_PARITY_EN
          checks++;
          if (fmt_parity !== e.par) begin
            errors++;
            $display("FAIL parity data=%h got %b exp %b", fmt_data, fmt_parity, e.par);
          end
`endif
        end
        if (fmt_end) in_pkt = 1'b0;
      end
    end
  end

  task automatic pcheck(input string name, input logic [31:0] got, input logic [31:0] exp);
    pchk_t p;
    p.name = name;
    p.got  = got;
    p.exp  = exp;
    pchk_q.push_back(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [1:0] id, input logic [31:0] w[$], input logic [5:0] len,
                          input int chg_at, input bit push_exp);
    exp_t x;
    for (int i = 0; i < w.size(); i++) begin
      if (i == chg_at) len_sel = 3'd0;
      arb_valid = 1'b1;
      arb_id    = id;
      arb_data  = w[i];
      pcheck("ready_collect", {31'd0, arb_ready}, 32'd1);
      if (push_exp) begin
        x.data  = w[i];
        x.start = (i == 0);
        x.last  = (i == w.size() - 1);
        x.chid  = id;
        x.len   = len;
        x.par   = ^w[i];
        exp_q.push_back(x);
      end
      tick();
      if (i < int'(len) - 1) pcheck("req_not_early", {31'd0, fmt_req}, 32'd0);
    end
    arb_valid = 1'b0;
  endtask

  task automatic grant_pkt(input int hold, input logic [1:0] ch, input logic [5:0] len);
    pcheck("req_rise", {31'd0, fmt_req}, 32'd1);
    pcheck("req_chid", {30'd0, fmt_chid}, {30'd0, ch});
    pcheck("req_len", {26'd0, fmt_length}, {26'd0, len});
    for (int i = 0; i < hold; i++) begin
      tick();
      pcheck("req_hold", {31'd0, fmt_req}, 32'd1);
      pcheck("ready_low_req", {31'd0, arb_ready}, 32'd0);
    end
    fmt_grant = 1'b1;
    tick();
    fmt_grant = 1'b0;
    pcheck("start_after_grant", {31'd0, fmt_start}, 32'd1);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!fmt_end && n < 100) begin
      tick();
      n++;
    end
    pcheck("end_seen", {31'd0, fmt_end}, 32'd1);
    tick();
    pcheck("gap_ready", {31'd0, arb_ready}, 32'd0);
    pcheck("gap_strobes", {29'd0, fmt_req, fmt_start, fmt_end}, 32'd0);
`ifdef MCDF_FMT_PARITY_EN
    pcheck("gap_parity", {31'd0, fmt_parity}, 32'd0);
`endif
    tick();
    pcheck("idle_ready", {31'd0, arb_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pkt[$];
    rst = 1'b1; arb_valid = 1'b0; arb_id = '0; arb_data = '0; len_sel = '0; fmt_grant = 1'b0;
    repeat (3) tick();
    pcheck("rst_ready", {31'd0, arb_ready}, 32'd1);
    pcheck("rst_outs", {29'd0, fmt_req, fmt_start, fmt_end}, 32'd0);
    pcheck("rst_chid_len", {24'd0, fmt_chid, fmt_length}, 32'd0);
    pcheck("rst_data", fmt_data, 32'd0);
    rst = 1'b0;
    tick();

    // 4-word packet on channel 2, immediate grant
    len_sel = 3'd0;
    pkt = '{32'h11, 32'h22, 32'h33, 32'h44};
    send_pkt(2'd2, pkt, 6'd4, -1, 1'b1);
    grant_pkt(0, 2'd2, 6'd4);
    wait_end();

    // 32 words, grant held off for 10 cycles
    len_sel = 3'd3;
    pkt.delete();
    for (int i = 0; i < 32; i++) pkt.push_back(32'h1000 + i);
    send_pkt(2'd1, pkt, 6'd32, -1, 1'b1);
    grant_pkt(10, 2'd1, 6'd32);
    wait_end();

    // len_sel drops to 0 after the third word; packet remains 8 words
    len_sel = 3'd1;
    pkt = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
    send_pkt(2'd3, pkt, 6'd8, 3, 1'b1);
    grant_pkt(0, 2'd3, 6'd8);
    wait_end();

    // back-to-back packets ch0 then ch1
    len_sel = 3'd0;
    pkt = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
    send_pkt(2'd0, pkt, 6'd4, -1, 1'b1);
    grant_pkt(0, 2'd0, 6'd4);
    wait_end();
    pkt = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
    send_pkt(2'd1, pkt, 6'd4, -1, 1'b1);
    grant_pkt(0, 2'd1, 6'd4);
    wait_end();

    // reset after two of four words, then a clean packet
    pkt = '{32'hB1, 32'hB2};
    send_pkt(2'd1, pkt, 6'd4, -1, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pcheck("post_rst_req", {31'd0, fmt_req}, 32'd0);
    pcheck("post_rst_ready", {31'd0, arb_ready}, 32'd1);
    pkt = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
    send_pkt(2'd3, pkt, 6'd4, -1, 1'b1);
    grant_pkt(0, 2'd3, 6'd4);
    wait_end();

`ifdef MCDF_FMT_PARITY_EN
    pkt = '{32'h7, 32'h3, 32'h7, 32'h3};
    send_pkt(2'd0, pkt, 6'd4, -1, 1'b1);
    grant_pkt(0, 2'd0, 6'd4);
    wait_end();
`endif

    pcheck("exp_q_drained", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcdf_formatter.md
Name: mcdf_formatter

Overview:
- Packet formatter stage of MCDF. Sits directly downstream of the channel arbiter and drives the formatter interface (fmt_*).
- Collects a fixed-length burst of 32-bit words from one channel into an internal buffer, then requests the outbound link.
- After grant, streams the packet out with start/end framing.
- Packet length comes from the register block's length selector.

Parameters:
- DATA_WIDTH, 32, width of channel and packet data words.
- BUF_DEPTH, 32, packet buffer depth in words; must be at least the maximum packet length.
- CHID_WIDTH, 2, channel identifier width.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- arb_valid  input  1  arbiter presents a word.
- arb_id  input  CHID_WIDTH  source channel of the presented word.
- arb_data  input  DATA_WIDTH  presented word.
- arb_ready  output  1  formatter accepts the word this cycle.
- len_sel  input  3  packet length select: 0→4, 1→8, 2→16, 3..7→32 words.
- fmt_grant  input  1  downstream grants the pending request.
- fmt_req  output  1  packet buffered, requesting transmission.
- fmt_chid  output  2  channel id of the packet.
- fmt_length  output  6  packet length in words (4/8/16/32).
- fmt_data  output  32  packet data word.
- fmt_start  output  1  first data word of packet.
- fmt_end  output  1  last data word of packet.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset: all outputs 0 except arb_ready=1. State=IDLE; counters, pointers and buffer contents cleared or invalidated.
- Reset asserted mid-packet discards the partial or pending packet. The first cycle after deassertion is IDLE.
- Handshake in: a word transfers when arb_valid && arb_ready at posedge. arb_ready = 1 in IDLE and COLLECT, 0 otherwise.
- Handshake out: fmt_chid and fmt_length are stable from fmt_req rise until the cycle fmt_end is high.
- All fmt_* outputs are registered.

State machine:
- IDLE: on a transfer, latch arb_id→pkt_id and decode len_sel→pkt_len; write the word to the buffer; cnt=1; go COLLECT.
- COLLECT: each transfer writes the buffer and increments cnt. On the transfer where cnt reaches pkt_len, go REQ.
- REQ: fmt_req=1, fmt_chid=pkt_id, fmt_length=pkt_len. Stay while fmt_grant=0. On fmt_grant=1 sampled, go SEND.
- SEND: fmt_req=0. One word per cycle from the buffer in write order.
  - First SEND cycle: fmt_start=1. This is exactly 1 cycle after grant is sampled.
  - Last word (word index pkt_len-1): fmt_end=1.
  - Then go GAP.
- GAP: one idle cycle, all fmt_* strobes 0, then IDLE.

Width and latch rules:
- len_sel is sampled only on the first word. Changes mid-packet are ignored.
- Words whose arb_id differs from pkt_id during COLLECT are still accepted and attributed to pkt_id. The arbiter guarantees a channel hold per packet.
- fmt_grant outside REQ is ignored. fmt_grant in the same cycle fmt_req first rises is honoured.
- Buffer read/write pointers are 5 bits and reset to 0 per packet; no wrap occurs within a packet.
- fmt_data holds its last value when not in SEND.

Latency and throughput:
- Minimum gap between the last input word and fmt_start is 2 cycles: REQ with immediate grant, then SEND.
- Maximum input throughput is 1 word per cycle during collection.

Optional Feature:
- MCDF_FMT_PARITY_EN
  - Defined: adds output port fmt_parity (1 bit) = XOR reduction of fmt_data, registered alongside fmt_data. It is 0 whenever not in SEND and 0 on reset.
  - Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then len_sel=0; push 4 words 0x11,0x22,0x33,0x44 with arb_id=2; grant immediately → fmt_req high with fmt_chid=2 and fmt_length=4; data 0x11..0x44 on 4 consecutive cycles; fmt_start on 0x11, fmt_end on 0x44.
- len_sel=3; push 32 incrementing words; hold fmt_grant=0 for 10 cycles → fmt_req stays high, arb_ready=0 throughout; after grant, 32 words in order with fmt_length=32.
- len_sel=1; change len_sel to 0 after the 3rd word → packet still 8 words, fmt_length=8.
- Two back-to-back 4-word packets from ch0 then ch1 → GAP of exactly 1 cycle after fmt_end, then IDLE; second packet has fmt_chid=1.
- Assert rst after 2 of 4 words are collected → next packet of 4 words is emitted intact with no stale data, and fmt_req is not raised early.
- With MCDF_FMT_PARITY_EN: word 0x00000007 → fmt_parity=1; word 0x00000003 → 0.
